// File: rtl/abram_distributor.sv
// 1-to-N ABRAM ad distributor: routes one upstream transaction to the port named by an address field.
// Optional REQ timeout is enabled with `define ABRAM_DISTRIBUTOR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for in_ad_valid; captures addr/data/dest
// REQ   | out_ad_valid[dest] held until out_ad_done[dest] (or timeout)
// DONE  | one-cycle in_ad_done to upstream, then back to IDLE
module abram_distributor #(
  parameter int OUTPUTS   = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 64,
  parameter int SEL_LSB   = 28,
  parameter int TIMEOUT   = 255
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_ad_valid,
  input  logic [ADDR_SIZE-1:0]                in_ad_addr,
  input  logic [DATA_SIZE-1:0]                in_ad_data,
  output logic                                in_ad_done,
  output logic [OUTPUTS-1:0]                  out_ad_valid,
  output logic [OUTPUTS-1:0][ADDR_SIZE-1:0]   out_ad_addr,
  output logic [OUTPUTS-1:0][DATA_SIZE-1:0]   out_ad_data,
  input  logic [OUTPUTS-1:0]                  out_ad_done,
  output logic                                busy,
  output logic                                err
);

  localparam int SEL_W = $clog2(OUTPUTS);

  if (OUTPUTS < 2 || TIMEOUT < 1 || SEL_LSB + SEL_W > ADDR_SIZE) begin : g_param_check
    $error("abram_distributor: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] data_q;
  logic [SEL_W-1:0]     dest_q;
  logic [SEL_W-1:0]     sel;
  logic                 sel_ok;
  logic [OUTPUTS-1:0]   sel_hot;
  logic                 req_done;

  assign sel      = in_ad_addr[SEL_LSB +: SEL_W];
  assign sel_hot  = OUTPUTS'(1) << sel;
  assign req_done = out_ad_done[dest_q];

  // Only a non-power-of-2 port count leaves field codes with no port behind them
  if ((2 ** SEL_W) == OUTPUTS) begin : g_full_range
    assign sel_ok = 1'b1;
  end else begin : g_part_range
    localparam logic [SEL_W:0] OUT_LIM = OUTPUTS[SEL_W:0];
    assign sel_ok = ({1'b0, sel} < OUT_LIM);
  end

  assign out_ad_addr = {OUTPUTS{addr_q}};
  assign out_ad_data = {OUTPUTS{data_q}};

`ifdef ABRAM_DISTRIBUTOR_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      dest_q       <= '0;
      out_ad_valid <= '0;
      in_ad_done   <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
`ifdef ABRAM_DISTRIBUTOR_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      in_ad_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (in_ad_valid) begin
            addr_q <= in_ad_addr;
            data_q <= in_ad_data;
            dest_q <= sel;
            busy   <= 1'b1;
            if (sel_ok) begin
              state        <= REQ;
              out_ad_valid <= sel_hot;
`ifdef ABRAM_DISTRIBUTOR_TIMEOUT_EN
              cnt          <= '0;
`endif
            end else begin
              // Bad destination still completes upstream, flagged with err
              state      <= DONE;
              in_ad_done <= 1'b1;
              err        <= 1'b1;
            end
          end
        end
        REQ: begin
          if (req_done) begin
            state        <= DONE;
            out_ad_valid <= '0;
            in_ad_done   <= 1'b1;
          end
`ifdef ABRAM_DISTRIBUTOR_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT)) begin
            state        <= DONE;
            out_ad_valid <= '0;
            in_ad_done   <= 1'b1;
            err          <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          out_ad_valid <= '0;
        end
      endcase
    end
  end

endmodule
